adder_result_buffer: RTL

//  Downstream stage of the 8-bit ripple-carry adder: captures {overflow, sum} results into a

---
 rtl/adder_result_buffer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/adder_result_buffer.sv
// Buffers {overflow, sum} adder results in a DEPTH-entry FIFO and keeps a saturating overflow count.
// Latency is 1 cycle push-to-out with no bypass. in_ready=!full, with no pass-through when full. ADDER_RESULT_SATURATE_EN clamps the stored sum.
module adder_result_buffer #(
  parameter int DEPTH         = 4,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_sum,
  input  logic                         in_overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_sum,
  output logic                         out_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [OVF_CNT_WIDTH-1:0]     ovf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       ovf;
    logic [7:0] sum;
  } entry_t;

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  entry_t                   mem_q [DEPTH];
  entry_t                   mem_d [DEPTH];

  logic   full_w;
  logic   empty_w;
  logic   push;
  logic   pop;
  entry_t wr_entry;
  entry_t head;

  always_comb begin
    full_w  = (count_q == CNT_W'(DEPTH));
    empty_w = (count_q == '0);
    push    = in_valid & ~full_w;
    pop     = out_ready & ~empty_w;

    wr_entry.ovf = in_overflow;
`ifdef ADDER_RESULT_SATURATE_EN
    wr_entry.sum = in_overflow ? 8'hFF : in_sum;
`else
    wr_entry.sum = in_sum;
`endif
  end

  // clear wins over any handshake in the same cycle
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_cnt_d = ovf_cnt_q;
    mem_d     = mem_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ovf_cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (in_overflow && (ovf_cnt_q != {OVF_CNT_WIDTH{1'b1}})) begin
          ovf_cnt_d = ovf_cnt_q + OVF_CNT_WIDTH'(1);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // storage holds data only; validity lives in count_q, so no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head         = mem_q[rd_ptr_q];
    in_ready     = ~full_w;
    out_valid    = ~empty_w;
    out_sum      = empty_w ? 8'h00 : head.sum;
    out_overflow = empty_w ? 1'b0  : head.ovf;
    count        = count_q;
    full         = full_w;
    empty        = empty_w;
    ovf_count    = ovf_cnt_q;
  end

endmodule
